// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage pipeline register.
// Carries a payload bus and a control bus through DEPTH register stages
// (legal 1..4). Each stage has its own valid bit, and there is a valid/ready
// handshake at both ends plus a global freeze (enable) and a flush.
// Control bits are cleared on every bubble, so downstream write-enables
// only fire on valid slots.
// Optional feature: define PIPE_STAGE_STALL_CNT_EN to add a saturating
// 16-bit stall_cnt output. It counts cycles where the output holds a valid
// entry that cannot leave.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int DEPTH  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    generate
        if (DEPTH < 1 || DEPTH > 4) begin : gBadDepth
            $error("pipe_stage_reg: DEPTH must be in 1..4");
        end
    endgenerate

    logic [DEPTH-1:0]  validQ;
    logic [DATA_W-1:0] dataQ [DEPTH];
    logic [CTRL_W-1:0] ctrlQ [DEPTH];

    logic [DEPTH-1:0]  take;
    logic [DEPTH-1:0]  srcValid;
    logic [DATA_W-1:0] srcData [DEPTH];
    logic [CTRL_W-1:0] srcCtrl [DEPTH];

    // Ready chain built from the output side. A stage may load when it is
    // empty or when the stage ahead of it is loading, so bubbles collapse.
    always_comb begin
        take = '0;
        take[DEPTH-1] = enable & (~validQ[DEPTH-1] | out_ready);
        for (int i = DEPTH - 2; i >= 0; i--) begin
            take[i] = enable & (~validQ[i] | take[i+1]);
        end
    end

    // Source of each stage: upstream inputs for stage 0, otherwise the previous stage
    always_comb begin
        srcValid   = '0;
        srcData[0] = in_data;
        srcCtrl[0] = in_ctrl;
        srcValid[0] = in_valid;
        for (int i = 1; i < DEPTH; i++) begin
            srcValid[i] = validQ[i-1];
            srcData[i]  = dataQ[i-1];
            srcCtrl[i]  = ctrlQ[i-1];
        end
    end

    // Stage registers. Reset clears everything. Flush kills valid and control
    // but keeps the payload. Otherwise each taking stage loads its source;
    // a bubble leaves the payload untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                validQ[i] <= 1'b0;
                dataQ[i]  <= '0;
                ctrlQ[i]  <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                validQ[i] <= 1'b0;
                ctrlQ[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (take[i]) begin
                    if (srcValid[i]) begin
                        validQ[i] <= 1'b1;
                        dataQ[i]  <= srcData[i];
                        ctrlQ[i]  <= srcCtrl[i];
                    end else begin
                        validQ[i] <= 1'b0;
                        ctrlQ[i]  <= '0;
                    end
                end
            end
        end
    end

    assign in_ready  = take[0] & ~flush & ~reset;
    assign out_valid = validQ[DEPTH-1];
    assign out_data  = dataQ[DEPTH-1];
    assign out_ctrl  = ctrlQ[DEPTH-1];

`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [15:0] stallQ;

    // Saturating count of cycles where a valid output entry is held back.
    // Only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            stallQ <= '0;
        end else if (validQ[DEPTH-1] && (!out_ready || !enable) && stallQ != 16'hFFFF) begin
            stallQ <= stallQ + 16'd1;
        end
    end

    assign stall_cnt = stallQ;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed scenarios followed by randomized traffic.
// The reference treats the pipe as an ordered array of slots. When the output
// drains, the whole array shifts. Otherwise the segment up to the highest
// empty slot shifts.
module tb_pipe_stage_reg;

    localparam int DEPTH = 3;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [7:0]  in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [7:0]  out_ctrl;
`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int nVec = 0;
    int nMis = 0;

    bit          mValid [DEPTH];
    logic [31:0] mData  [DEPTH];
    logic [7:0]  mCtrl  [DEPTH];
    int          mStall = 0;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl)
`ifdef PIPE_STAGE_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare the DUT against the slot model before the coming edge
    task automatic checkOutput();
        bit anyEmpty;
        bit expReady;
        anyEmpty = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!mValid[i]) anyEmpty = 1'b1;
        end
        expReady = !reset && !flush && enable && (out_ready || anyEmpty);
        compare("in_ready", 32'(in_ready), 32'(expReady));
        compare("out_valid", 32'(out_valid), 32'(mValid[DEPTH-1]));
        compare("out_ctrl", 32'(out_ctrl), mValid[DEPTH-1] ? 32'(mCtrl[DEPTH-1]) : 32'd0);
        if (mValid[DEPTH-1]) begin
            compare("out_data", out_data, mData[DEPTH-1]);
        end
`ifdef PIPE_STAGE_STALL_CNT_EN
        compare("stall_cnt", 32'(stall_cnt), 32'(mStall));
`endif
    endtask

    // Move the slot model forward by one clock edge using the current inputs
    task automatic modelUpdate();
        int k;
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mValid[i] = 1'b0;
            mStall = 0;
        end else begin
            if (mValid[DEPTH-1] && (!out_ready || !enable) && mStall < 65535) mStall++;
            if (flush) begin
                for (int i = 0; i < DEPTH; i++) mValid[i] = 1'b0;
            end else if (enable) begin
                k = -1;
                if (out_ready) begin
                    k = DEPTH - 1;
                end else begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (!mValid[i]) k = i;
                    end
                end
                if (k >= 0) begin
                    for (int i = k; i >= 1; i--) begin
                        mValid[i] = mValid[i-1];
                        mData[i]  = mData[i-1];
                        mCtrl[i]  = mCtrl[i-1];
                    end
                    mValid[0] = in_valid;
                    mData[0]  = in_data;
                    mCtrl[0]  = in_ctrl;
                end
            end
        end
    endtask

    task automatic applyStimulus(input bit iv, input logic [31:0] d, input logic [7:0] c,
                                 input bit ordy, input bit en, input bit fl, input bit rst);
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        enable    = en;
        flush     = fl;
        reset     = rst;
        #2;
        checkOutput();
    endtask

    task automatic advance();
        @(posedge clk);
        modelUpdate();
    endtask

    // Directed scenarios, then random traffic, then the summary
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mValid[i] = 1'b0;
            mData[i]  = '0;
            mCtrl[i]  = '0;
        end
        in_valid = 1'b0; in_data = '0; in_ctrl = '0;
        out_ready = 1'b1; enable = 1'b1; flush = 1'b0; reset = 1'b1;
        advance();

        applyStimulus(1'b0, 32'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        compare("rst_in_ready", 32'(in_ready), 32'd0);
        compare("rst_out_valid", 32'(out_valid), 32'd0);
        compare("rst_out_data", out_data, 32'd0);
        compare("rst_out_ctrl", 32'(out_ctrl), 32'd0);
        advance();

        applyStimulus(1'b1, 32'hDEAD_BEEF, 8'h05, 1'b1, 1'b1, 1'b0, 1'b0);
        compare("single_in_ready", 32'(in_ready), 32'd1);
        advance();
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b0, 32'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);
            advance();
        end
        applyStimulus(1'b0, 32'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        compare("single_out_valid", 32'(out_valid), 32'd1);
        compare("single_out_data", out_data, 32'hDEAD_BEEF);
        compare("single_out_ctrl", 32'(out_ctrl), 32'h05);
        advance();
        applyStimulus(1'b0, 32'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        compare("single_gone_valid", 32'(out_valid), 32'd0);
        compare("single_gone_ctrl", 32'(out_ctrl), 32'd0);
        advance();

        for (int k = 0; k < 8; k++) begin
            applyStimulus(k < 4, 32'(k + 1), 8'(k + 1), 1'b1, 1'b1, 1'b0, 1'b0);
            compare("stream_in_ready", 32'(in_ready), 32'd1);
            if (k >= 3 && k <= 6) begin
                compare("stream_out_valid", 32'(out_valid), 32'd1);
                compare("stream_out_data", out_data, 32'(k - 2));
            end
            advance();
        end

        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 32'(11 + k), 8'(8'h10 + k), 1'b0, 1'b1, 1'b0, 1'b0);
            compare("bp_in_ready", 32'(in_ready), (k < 3) ? 32'd1 : 32'd0);
            advance();
        end
        for (int k = 0; k < 4; k++) begin
            applyStimulus(k == 0, 32'd14, 8'h13, 1'b1, 1'b1, 1'b0, 1'b0);
            if (k == 0) compare("bp_accept_4th", 32'(in_ready), 32'd1);
            compare("bp_out_data", out_data, 32'(11 + k));
            advance();
        end

        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b1, 32'(21 + k), 8'h21, 1'b1, 1'b1, 1'b0, 1'b0);
            advance();
        end
        applyStimulus(1'b1, 32'd99, 8'h99, 1'b1, 1'b1, 1'b1, 1'b0);
        compare("flush_in_ready", 32'(in_ready), 32'd0);
        advance();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 32'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);
            compare("flush_out_valid", 32'(out_valid), 32'd0);
            compare("flush_out_ctrl", 32'(out_ctrl), 32'd0);
            advance();
        end

        applyStimulus(1'b0, 32'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        advance();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 32'(31 + k), 8'(8'h30 + k), 1'b0, 1'b1, 1'b0, 1'b0);
            advance();
        end
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b1, 32'hAAAA_0000, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b0);
            compare("freeze_out_valid", 32'(out_valid), 32'd1);
            compare("freeze_out_data", out_data, 32'd31);
            compare("freeze_in_ready", 32'(in_ready), 32'd0);
            advance();
        end
        applyStimulus(1'b0, 32'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        compare("frozen_held_data", out_data, 32'd31);
`ifdef PIPE_STAGE_STALL_CNT_EN
        compare("freeze_stall_cnt", 32'(stall_cnt), 32'd2);
`endif
        advance();
        applyStimulus(1'b0, 32'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        compare("post_rst_valid", 32'(out_valid), 32'd0);
        compare("post_rst_data", out_data, 32'd0);
        compare("post_rst_ctrl", 32'(out_ctrl), 32'd0);
        compare("post_rst_in_ready", 32'(in_ready), 32'd1);
        advance();

        for (int k = 0; k < 2000; k++) begin
            applyStimulus($urandom_range(0, 9) < 7, $urandom, 8'($urandom),
                          $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 9,
                          $urandom_range(0, 39) == 0, $urandom_range(0, 199) == 0);
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
